shiftreg_tx_sequencer: RTL and testbench
========================================

Name: shiftreg_tx_sequencer

Overview:
Sequencer that owns a WIDTH-bit shift register and drives it as a paced parallel-to-serial transmitter.
- Accepts one parallel word per transaction through a valid/ready handshake.
- Shifts the word out LSB-first, one bit every DIV clocks.
- Reports progress and completion to the upstream controller.
- Sits between a register/command source and a serial output pin or downstream serial consumer.

Parameters:
- WIDTH, 5: word length in bits (>=1).
- DIV, 4: clocks per serial bit (>=1; DIV=1 shifts every clock).

Ports:
- clk, input, 1: system clock, all logic on posedge.
- rst, input, 1: synchronous active-high reset.
- i_data, input, WIDTH: parallel word to transmit.
- i_valid, input, 1: i_data is valid.
- o_ready, output, 1: sequencer can accept a word.
- i_abort, input, 1: cancel the current transfer.
- o_sdata, output, 1: serial data bit.
- o_shift_stb, output, 1: one-clock strobe on the last clock of each bit period.
- o_busy, output, 1: transfer in progress.
- o_done, output, 1: one-clock pulse after the last bit completes.
- o_bits_left, output, clog2(WIDTH+1): bits not yet fully transmitted.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, rst).

Reset:
- State goes to IDLE; shift reg, divider and bit counter clear to 0.
- Output reset values: o_ready=1, o_sdata=0, o_shift_stb=0, o_busy=0, o_done=0, o_bits_left=0.
- Reset overrides every other input in the same cycle, including mid-transfer. An aborted word is lost, and no o_done is produced.

States: IDLE, SHIFT, DONE.

IDLE:
- o_ready=1, o_busy=0.
- Accept: i_valid&&o_ready at a posedge loads i_data into the shift reg, sets divider=0 and bit count=WIDTH, then goes to SHIFT.
- o_ready is 0 from the next cycle.

SHIFT:
- o_busy=1, o_ready=0, o_sdata=shiftreg[0], o_bits_left=remaining count.
- Divider counts 0..DIV-1 and wraps.
- o_shift_stb=1 exactly while divider==DIV-1.
- On that edge:
  - shift reg shifts right with 0 fill;
  - count decrements;
  - when count reaches 0, go to DONE.

DONE:
- Lasts one cycle: o_done=1, o_busy=0, o_ready=0, o_sdata=0, o_bits_left=0.
- Next state is IDLE.

Timing (accept at edge E0):
- The first bit is visible in cycle 1.
- Strobes occur in cycles DIV, 2*DIV, ..., WIDTH*DIV.
- o_done is high in cycle WIDTH*DIV+1.
- o_ready is high again in cycle WIDTH*DIV+2.
- Minimum back-to-back spacing between accepts is WIDTH*DIV+2 clocks.

Abort:
- i_abort=1 in SHIFT takes effect at the next edge: go to IDLE, clear the shift reg, divider and count, and do not pulse o_done.
- Abort wins over a coincident final strobe, i.e. the last bit is not reported done.
- i_abort is ignored in IDLE and DONE.

Other rules:
- i_valid outside IDLE is ignored; the word is not captured and no error is raised.
- i_data is sampled only on the accept edge; changes afterwards have no effect.
- No X on outputs after reset.

Test Plan:
1. WIDTH=5, DIV=4, reset, then i_data=5'b10110 with i_valid for 1 cycle:
   - o_sdata holds 0,1,1,0,1, each for 4 cycles;
   - o_shift_stb high in cycles 4,8,12,16,20;
   - o_bits_left goes 5,4,3,2,1;
   - o_done high only in cycle 21;
   - o_ready returns in cycle 22.
2. DIV=1, WIDTH=5, i_data=5'b11111 accepted:
   - o_shift_stb high in cycles 1-5;
   - o_done in cycle 6;
   - a second word held valid is accepted at the cycle-7 edge.
3. i_valid held high with changing i_data during SHIFT:
   - the in-flight serial stream is unchanged;
   - the next word is captured only when o_ready=1.
4. i_abort asserted in cycle 10 of the transfer in case 1:
   - IDLE, o_ready=1, o_busy=0 in cycle 11;
   - no o_done pulse.
5. rst asserted in cycle 7 mid-transfer:
   - next cycle all outputs at reset values, o_ready=1;
   - a new word is then transmitted correctly from bit 0.
6. i_abort coincident with the final strobe (cycle 20):
   - no o_done;
   - IDLE in cycle 21.

Source files
------------

// File: rtl/shiftreg_tx_sequencer.sv
// Paced parallel-to-serial transmitter: accepts a word over valid/ready and
// shifts it out LSB-first, one bit every DIV clocks, with progress/done status.
module shiftreg_tx_sequencer #(
  parameter int WIDTH = 5,
  parameter int DIV   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic                       i_abort,
  output logic                       o_sdata,
  output logic                       o_shift_stb,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [$clog2(WIDTH+1)-1:0] o_bits_left
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [DW-1:0]    r_div;
  logic [CW-1:0]    r_cnt;
  logic             w_stb;
  logic             w_accept;

  assign w_stb    = (r_state == S_SHIFT) && (r_div == DIV_LAST);
  assign w_accept = (r_state == S_IDLE) && i_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Abort takes priority over the final strobe, so an aborted word never reaches DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_valid) w_state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (i_abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_stb && (r_cnt == CW'(1))) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_shreg <= i_data;
      r_div   <= '0;
      r_cnt   <= CW'(WIDTH);
    end else if (r_state == S_SHIFT) begin
      if (i_abort) begin
        r_shreg <= '0;
        r_div   <= '0;
        r_cnt   <= '0;
      end else if (w_stb) begin
        r_shreg <= r_shreg >> 1;
        r_div   <= '0;
        r_cnt   <= r_cnt - CW'(1);
      end else begin
        r_div   <= r_div + DW'(1);
      end
    end
  end

  always_comb begin
    o_ready     = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    o_sdata     = 1'b0;
    o_shift_stb = 1'b0;
    o_bits_left = '0;
    case (r_state)
      S_IDLE:  o_ready = 1'b1;
      S_SHIFT: begin
        o_busy      = 1'b1;
        o_sdata     = r_shreg[0];
        o_shift_stb = w_stb;
        o_bits_left = r_cnt;
      end
      S_DONE:  o_done = 1'b1;
      default: o_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_shiftreg_tx_sequencer.sv
// Directed bench for shiftreg_tx_sequencer: a DIV=4 instance and a DIV=1 instance,
// both WIDTH=5, checked cycle by cycle against hand-derived expectations.
module tb_shiftreg_tx_sequencer;

  logic       clk;
  logic       rst;

  logic [4:0] a_data;
  logic       a_valid, a_abort;
  logic       a_ready, a_sdata, a_stb, a_busy, a_done;
  logic [2:0] a_left;

  logic [4:0] b_data;
  logic       b_valid, b_abort;
  logic       b_ready, b_sdata, b_stb, b_busy, b_done;
  logic [2:0] b_left;

  int n_checks = 0;
  int n_fail   = 0;

  shiftreg_tx_sequencer #(.WIDTH(5), .DIV(4)) u_dut_a (
    .clk(clk), .rst(rst), .i_data(a_data), .i_valid(a_valid), .o_ready(a_ready),
    .i_abort(a_abort), .o_sdata(a_sdata), .o_shift_stb(a_stb), .o_busy(a_busy),
    .o_done(a_done), .o_bits_left(a_left)
  );

  shiftreg_tx_sequencer #(.WIDTH(5), .DIV(1)) u_dut_b (
    .clk(clk), .rst(rst), .i_data(b_data), .i_valid(b_valid), .o_ready(b_ready),
    .i_abort(b_abort), .o_sdata(b_sdata), .o_shift_stb(b_stb), .o_busy(b_busy),
    .o_done(b_done), .o_bits_left(b_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected outputs of the DIV=4 instance in cycle c (1..20) of a transfer of word w.
  task automatic chk_a_shift(input string tn, input int c, input logic [4:0] w);
    int bi;
    bi = (c - 1) / 4;
    chk($sformatf("%s sdata c%0d", tn, c), a_sdata, w[bi]);
    chk($sformatf("%s stb c%0d", tn, c), a_stb, (c % 4) == 0);
    chk($sformatf("%s left c%0d", tn, c), a_left, 5 - bi);
    chk($sformatf("%s busy c%0d", tn, c), a_busy, 1);
    chk($sformatf("%s ready c%0d", tn, c), a_ready, 0);
    chk($sformatf("%s done c%0d", tn, c), a_done, 0);
  endtask

  task automatic chk_a_idle(input string tn);
    chk({tn, " ready"}, a_ready, 1);
    chk({tn, " busy"}, a_busy, 0);
    chk({tn, " done"}, a_done, 0);
    chk({tn, " sdata"}, a_sdata, 0);
    chk({tn, " stb"}, a_stb, 0);
    chk({tn, " left"}, a_left, 0);
  endtask

  task automatic accept_a(input logic [4:0] w);
    a_data  = w;
    a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    a_data  = 5'b01010;
  endtask

  initial begin
    rst = 1'b1;
    a_data = '0; a_valid = 1'b0; a_abort = 1'b0;
    b_data = '0; b_valid = 1'b0; b_abort = 1'b0;
    tick();
    tick();
    chk_a_idle("reset");
    chk("reset b ready", b_ready, 1);
    chk("reset b busy", b_busy, 0);
    rst = 1'b0;
    tick();

    // Full transfer of 5'b10110 at DIV=4
    accept_a(5'b10110);
    for (int c = 1; c <= 20; c++) begin
      chk_a_shift("t1", c, 5'b10110);
      tick();
    end
    chk("t1 done c21", a_done, 1);
    chk("t1 busy c21", a_busy, 0);
    chk("t1 ready c21", a_ready, 0);
    chk("t1 sdata c21", a_sdata, 0);
    chk("t1 left c21", a_left, 0);
    tick();
    chk_a_idle("t1 c22");

    // DIV=1: strobe every clock; a second word held valid is taken at the cycle-7 edge
    b_data = 5'b11111;
    b_valid = 1'b1;
    tick();
    b_data = 5'b00101;
    for (int c = 1; c <= 5; c++) begin
      chk($sformatf("t2 stb c%0d", c), b_stb, 1);
      chk($sformatf("t2 sdata c%0d", c), b_sdata, 1);
      chk($sformatf("t2 left c%0d", c), b_left, 6 - c);
      chk($sformatf("t2 done c%0d", c), b_done, 0);
      tick();
    end
    chk("t2 done c6", b_done, 1);
    chk("t2 ready c6", b_ready, 0);
    tick();
    chk("t2 ready c7", b_ready, 1);
    chk("t2 busy c7", b_busy, 0);
    tick();
    b_valid = 1'b0;
    chk("t2 w2 busy c8", b_busy, 1);
    chk("t2 w2 sdata b0", b_sdata, 1);
    chk("t2 w2 left", b_left, 5);
    tick();
    chk("t2 w2 sdata b1", b_sdata, 0);
    tick();
    chk("t2 w2 sdata b2", b_sdata, 1);
    for (int i = 0; i < 5; i++) tick();
    chk("t2 w2 ready end", b_ready, 1);

    // i_valid held with changing i_data during SHIFT must not disturb the stream
    a_data = 5'b01001;
    a_valid = 1'b1;
    tick();
    for (int c = 1; c <= 20; c++) begin
      a_data = 5'(c * 7);
      chk_a_shift("t3", c, 5'b01001);
      tick();
    end
    chk("t3 done c21", a_done, 1);
    tick();
    chk("t3 ready c22", a_ready, 1);
    a_data = 5'b10110;
    tick();
    a_valid = 1'b0;
    a_data = 5'b00000;

    // Second word captured; abort in its cycle 10
    for (int c = 1; c <= 9; c++) begin
      chk_a_shift("t4", c, 5'b10110);
      tick();
    end
    chk_a_shift("t4", 10, 5'b10110);
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    chk_a_idle("t4 c11");
    tick();
    chk("t4 done c12", a_done, 0);
    tick();
    chk("t4 done c13", a_done, 0);

    // Abort in IDLE is ignored: the word is still accepted
    a_abort = 1'b1;
    accept_a(5'b00001);
    a_abort = 1'b0;
    chk_a_shift("t4i", 1, 5'b00001);
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;

    // Reset in cycle 7 mid-transfer, then a clean transfer from bit 0
    accept_a(5'b01101);
    for (int c = 1; c <= 6; c++) begin
      chk_a_shift("t5a", c, 5'b01101);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_a_idle("t5 rst");
    accept_a(5'b10011);
    for (int c = 1; c <= 20; c++) begin
      chk_a_shift("t5b", c, 5'b10011);
      tick();
    end
    chk("t5 done c21", a_done, 1);
    tick();
    chk("t5 ready c22", a_ready, 1);

    // Abort coincident with the final strobe
    accept_a(5'b11001);
    for (int c = 1; c <= 20; c++) begin
      chk_a_shift("t6", c, 5'b11001);
      if (c < 20) tick();
    end
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    chk_a_idle("t6 c21");
    tick();
    chk("t6 done c22", a_done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
